// File: rtl/hd44780_framebuf.sv
// Writable HD44780 character shadow buffer: cursor-based host write port,
// DDRAM-addressed registered read port and per-row dirty flags.
module hd44780_framebuf #(
  parameter int         ROWS = 2,
  parameter int         COLS = 16,
  parameter logic [7:0] FILL = 8'h20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [7:0]      wr_data,
  input  logic            pos_valid,
  input  logic [1:0]      pos_row,
  input  logic [5:0]      pos_col,
  input  logic            clr_start,
  output logic            busy,
  output logic [1:0]      cur_row,
  output logic [5:0]      cur_col,
  input  logic [6:0]      rd_addr,
  output logic [7:0]      rd_data,
  output logic [ROWS-1:0] dirty,
  input  logic [ROWS-1:0] dirty_clr
);

  localparam int         CELLS    = ROWS * COLS;
  localparam int         AW       = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [6:0] LAST_IDX = 7'(CELLS - 1);
  localparam logic [6:0] NCOLS    = 7'(COLS);
  localparam logic [5:0] NCOLS6   = 6'(COLS);
  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);
  localparam logic [2:0] NROWS    = 3'(ROWS);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t          state, state_d;
  logic [6:0]      clr_idx, clr_idx_d;
  logic [1:0]      row_d;
  logic [5:0]      col_d;
  logic [ROWS-1:0] dirty_d;
  logic [ROWS-1:0] row_mask;
  logic [6:0]      cur_idx;
  logic            we;
  logic [6:0]      waddr;
  logic [7:0]      wdata;
  logic [7:0]      mem [CELLS];

  logic [5:0]      rd_off_p0;
  logic [1:0]      rd_row_p0;
  logic [5:0]      rd_col_p0;
  logic            rd_hit_p0;
  logic [6:0]      rd_idx_p0;

  assign busy     = (state == S_CLEAR);
  assign wr_ready = !busy;
  assign cur_idx  = 7'(cur_row) * NCOLS + 7'(cur_col);
  assign row_mask = ROWS'(1) << cur_row;

  always_comb begin
    state_d   = state;
    clr_idx_d = clr_idx;
    row_d     = cur_row;
    col_d     = cur_col;
    dirty_d   = dirty & ~dirty_clr;
    we        = 1'b0;
    waddr     = clr_idx;
    wdata     = FILL;
    case (state)
      S_CLEAR: begin
        we = 1'b1;
        if (clr_start) begin
          clr_idx_d = '0;
          dirty_d   = '1;
        end else if (clr_idx == LAST_IDX) begin
          state_d   = S_IDLE;
          clr_idx_d = '0;
          row_d     = '0;
          col_d     = '0;
        end else begin
          clr_idx_d = clr_idx + 7'd1;
        end
      end
      S_IDLE: begin
        if (clr_start) begin
          state_d   = S_CLEAR;
          clr_idx_d = '0;
          dirty_d   = '1;
        end else if (pos_valid) begin
          // Out-of-range positions are dropped, and so is any write this cycle.
          if (({1'b0, pos_row} < NROWS) && (pos_col < NCOLS6)) begin
            row_d = pos_row;
            col_d = pos_col;
          end
        end else if (wr_valid) begin
          we      = 1'b1;
          waddr   = cur_idx;
          wdata   = wr_data;
          dirty_d = dirty_d | row_mask;
          if (cur_col < LAST_COL) begin
            col_d = cur_col + 6'd1;
          end else begin
            col_d = '0;
            row_d = (cur_row == LAST_ROW) ? 2'd0 : cur_row + 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_CLEAR;
      clr_idx <= '0;
      cur_row <= '0;
      cur_col <= '0;
      dirty   <= '1;
    end else begin
      state   <= state_d;
      clr_idx <= clr_idx_d;
      cur_row <= row_d;
      cur_col <= col_d;
      dirty   <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && rst_n) mem[waddr[AW-1:0]] <= wdata;
  end

  // DDRAM decode: bit 6 selects rows 1/3, offsets past COLS select rows 2/3.
  assign rd_off_p0 = rd_addr[5:0];

  always_comb begin
    rd_hit_p0 = 1'b0;
    rd_row_p0 = '0;
    rd_col_p0 = '0;
    if (rd_off_p0 < NCOLS6) begin
      rd_row_p0 = {1'b0, rd_addr[6]};
      rd_col_p0 = rd_off_p0;
      rd_hit_p0 = !rd_addr[6] || (ROWS >= 2);
    end else if ((ROWS == 4) && ({1'b0, rd_off_p0} < 7'(2 * COLS))) begin
      rd_row_p0 = {1'b1, rd_addr[6]};
      rd_col_p0 = rd_off_p0 - NCOLS6;
      rd_hit_p0 = 1'b1;
    end
  end

  assign rd_idx_p0 = 7'(rd_row_p0) * NCOLS + 7'(rd_col_p0);

  // ---- stage p1: registered read, old data wins on a same-cycle write ----
  always_ff @(posedge clk) begin
    if (!rst_n) rd_data <= FILL;
    else        rd_data <= rd_hit_p0 ? mem[rd_idx_p0[AW-1:0]] : FILL;
  end

endmodule

// File: tb/tb_hd44780_framebuf.sv
// Bench for hd44780_framebuf: a 2x16 and a 4x20 instance share stimulus;
// reads are checked through an expected-data queue one cycle after issue.
module tb_hd44780_framebuf;

  logic       clk = 1'b0;
  logic       rst_n, wr_valid, pos_valid, clr_start;
  logic [7:0] wr_data;
  logic [1:0] pos_row;
  logic [5:0] pos_col;
  logic [6:0] rd_addr;
  logic [3:0] dirty_clr;

  logic       wr_ready2, busy2, wr_ready4, busy4;
  logic [1:0] row2, row4;
  logic [5:0] col2, col4;
  logic [7:0] rd2, rd4;
  logic [1:0] dirty2;
  logic [3:0] dirty4;

  always #5 clk = ~clk;

  hd44780_framebuf #(.ROWS(2), .COLS(16), .FILL(8'h20)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready2),
    .wr_data(wr_data), .pos_valid(pos_valid), .pos_row(pos_row), .pos_col(pos_col),
    .clr_start(clr_start), .busy(busy2), .cur_row(row2), .cur_col(col2),
    .rd_addr(rd_addr), .rd_data(rd2), .dirty(dirty2), .dirty_clr(dirty_clr[1:0])
  );

  hd44780_framebuf #(.ROWS(4), .COLS(20), .FILL(8'h20)) dut4 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready4),
    .wr_data(wr_data), .pos_valid(pos_valid), .pos_row(pos_row), .pos_col(pos_col),
    .clr_start(clr_start), .busy(busy4), .cur_row(row4), .cur_col(col4),
    .rd_addr(rd_addr), .rd_data(rd4), .dirty(dirty4), .dirty_clr(dirty_clr)
  );

  typedef struct {
    int         grp;
    logic       wv;
    logic [7:0] wd;
    logic       pv;
    logic [1:0] prow;
    logic [5:0] pcol;
    logic [1:0] erow;
    logic [5:0] ecol;
  } vec_t;

  typedef struct {
    int         grp;
    logic [6:0] addr;
    logic [7:0] exp;
  } rvec_t;

  vec_t       vq[$];
  rvec_t      rq[$];
  logic [7:0] exp_q[$];
  logic [6:0] addr_q[$];
  logic       rd_pend = 1'b0;
  logic       sel4 = 1'b0;
  int         ncmp = 0;
  int         nfail = 0;

  function automatic vec_t mv(int g, logic wv, logic [7:0] wd, logic pv,
                              logic [1:0] pr, logic [5:0] pc,
                              logic [1:0] er, logic [5:0] ec);
    vec_t v;
    v = '{g, wv, wd, pv, pr, pc, er, ec};
    return v;
  endfunction

  function automatic rvec_t rv(int g, logic [6:0] a, logic [7:0] e);
    rvec_t r;
    r = '{g, a, e};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    logic [7:0] e;
    logic [6:0] a;
    @(posedge clk);
    #1;
    if (rd_pend) begin
      rd_pend = 1'b0;
      e = exp_q.pop_front();
      a = addr_q.pop_front();
      chk($sformatf("rd_data@%02h", a), sel4 ? rd4 : rd2, e);
    end
  endtask

  task automatic issue_read(input logic [6:0] a, input logic [7:0] e);
    rd_addr = a;
    exp_q.push_back(e);
    addr_q.push_back(a);
    rd_pend = 1'b1;
  endtask

  task automatic run_vecs(input int g);
    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].grp != g) continue;
      wr_valid  = vq[i].wv;
      wr_data   = vq[i].wd;
      pos_valid = vq[i].pv;
      pos_row   = vq[i].prow;
      pos_col   = vq[i].pcol;
      tick();
      wr_valid  = 1'b0;
      pos_valid = 1'b0;
      chk($sformatf("cur_row v%0d", i), sel4 ? row4 : row2, vq[i].erow);
      chk($sformatf("cur_col v%0d", i), sel4 ? col4 : col2, vq[i].ecol);
    end
  endtask

  task automatic run_reads(input int g);
    for (int i = 0; i < rq.size(); i++) begin
      if (rq[i].grp != g) continue;
      issue_read(rq[i].addr, rq[i].exp);
      tick();
    end
  endtask

  // Release reset and report the edge index (1 = first released edge) at which busy drops.
  task automatic release_and_time();
    int n2, n4;
    n2 = 0;
    n4 = 0;
    rst_n = 1'b1;
    for (int i = 1; i <= 200 && (n2 == 0 || n4 == 0); i++) begin
      tick();
      if (!busy2 && n2 == 0) n2 = i;
      if (!busy4 && n4 == 0) n4 = i;
    end
    chk("sweep2_len", n2, 32);
    chk("sweep4_len", n4, 80);
    chk("cursor_after_sweep", {row2, col2}, 8'h00);
    chk("wr_ready_idle", wr_ready2, 1);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; wr_valid = 1'b0; pos_valid = 1'b0; clr_start = 1'b0;
    wr_data = '0; pos_row = '0; pos_col = '0; rd_addr = '0; dirty_clr = '0;

    vq.push_back(mv(0, 1, "H", 0, 0, 0,  0, 1));
    vq.push_back(mv(0, 1, "e", 0, 0, 0,  0, 2));
    vq.push_back(mv(0, 1, "l", 0, 0, 0,  0, 3));
    vq.push_back(mv(0, 1, "l", 0, 0, 0,  0, 4));
    vq.push_back(mv(0, 1, "o", 0, 0, 0,  0, 5));
    vq.push_back(mv(0, 0, 0,   1, 0, 15, 0, 15));
    vq.push_back(mv(0, 1, "A", 0, 0, 0,  1, 0));
    vq.push_back(mv(0, 1, "B", 0, 0, 0,  1, 1));
    vq.push_back(mv(0, 0, 0,   1, 2, 3,  1, 1));
    vq.push_back(mv(0, 0, 0,   1, 0, 16, 1, 1));
    vq.push_back(mv(0, 0, 0,   1, 1, 15, 1, 15));
    vq.push_back(mv(0, 1, "Z", 0, 0, 0,  0, 0));
    vq.push_back(mv(0, 1, "Q", 1, 1, 2,  1, 2));
    vq.push_back(mv(2, 0, 0,   1, 2, 0,  2, 0));
    vq.push_back(mv(2, 1, "X", 0, 0, 0,  2, 1));
    vq.push_back(mv(2, 0, 0,   1, 3, 19, 3, 19));
    vq.push_back(mv(2, 1, "Y", 0, 0, 0,  0, 0));

    rq.push_back(rv(1, 7'h00, "H"));  rq.push_back(rv(1, 7'h01, "e"));
    rq.push_back(rv(1, 7'h02, "l"));  rq.push_back(rv(1, 7'h03, "l"));
    rq.push_back(rv(1, 7'h04, "o"));  rq.push_back(rv(1, 7'h05, 8'h20));
    rq.push_back(rv(1, 7'h0F, "A"));  rq.push_back(rv(1, 7'h40, "B"));
    rq.push_back(rv(1, 7'h41, 8'h20)); rq.push_back(rv(1, 7'h42, "w"));
    rq.push_back(rv(1, 7'h4F, "Z"));  rq.push_back(rv(1, 7'h10, 8'h20));
    rq.push_back(rv(1, 7'h50, 8'h20)); rq.push_back(rv(1, 7'h7F, 8'h20));
    rq.push_back(rv(2, 7'h14, "X"));  rq.push_back(rv(2, 7'h67, "Y"));
    rq.push_back(rv(2, 7'h00, 8'h20)); rq.push_back(rv(2, 7'h15, 8'h20));
    rq.push_back(rv(2, 7'h53, 8'h20)); rq.push_back(rv(2, 7'h28, 8'h20));

    tick(); tick();
    chk("rst_busy2", busy2, 1);
    chk("rst_wr_ready2", wr_ready2, 0);
    chk("rst_cursor2", {row2, col2}, 8'h00);
    chk("rst_rd_data2", rd2, 8'h20);
    chk("rst_dirty2", dirty2, 2'b11);
    chk("rst_dirty4", dirty4, 4'hF);

    release_and_time();
    chk("dirty_after_sweep", dirty2, 2'b11);
    for (int i = 0; i < 32; i++) begin
      issue_read((i < 16) ? 7'(i) : 7'(8'h40 + i - 16), 8'h20);
      tick();
    end

    run_vecs(0);
    issue_read(7'h42, 8'h20);
    tick();
    dirty_clr = 4'b0001; tick(); dirty_clr = '0;
    chk("dirty_clr_row0", dirty2, 2'b10);
    dirty_clr = 4'b0010; tick(); dirty_clr = '0;
    chk("dirty_clr_row1", dirty2, 2'b00);
    wr_valid = 1'b1; wr_data = "w"; dirty_clr = 4'b0010;
    tick();
    wr_valid = 1'b0; dirty_clr = '0;
    chk("dirty_set_wins", dirty2, 2'b10);
    chk("cursor_after_w", {row2, col2}, {2'd1, 6'd3});
    issue_read(7'h43, 8'h20);
    wr_valid = 1'b1; wr_data = "v";
    tick();
    wr_valid = 1'b0;
    issue_read(7'h43, "v");
    tick();
    run_reads(1);

    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0; tick();
    chk("midsweep_rst_busy", busy2, 1);
    chk("midsweep_rst_cursor", {row2, col2}, 8'h00);
    chk("midsweep_rst_dirty", dirty2, 2'b11);
    release_and_time();

    clr_start = 1'b1; wr_valid = 1'b1; wr_data = "K";
    tick();
    clr_start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy2) break;
      cnt++;
      if (i == 7) clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
    end
    wr_valid = 1'b0;
    chk("restart_busy_len", cnt, 40);
    chk("busy_wr_cursor", {row2, col2}, 8'h00);
    issue_read(7'h00, 8'h20); tick();
    issue_read(7'h43, 8'h20); tick();
    for (int i = 0; i < 200 && busy4; i++) tick();
    chk("dut4_idle", busy4, 0);

    sel4 = 1'b1;
    dirty_clr = 4'hF; tick(); dirty_clr = '0;
    chk("dirty4_clr_all", dirty4, 4'h0);
    run_vecs(2);
    chk("dirty4_rows23", dirty4, 4'b1100);
    run_reads(2);
    clr_start = 1'b1; dirty_clr = 4'hF;
    tick();
    clr_start = 1'b0; dirty_clr = '0;
    chk("dirty4_clr_wins", dirty4, 4'hF);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy4) break;
      cnt++;
      tick();
    end
    chk("clear4_busy_len", cnt, 80);
    issue_read(7'h14, 8'h20); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/hd44780_framebuf.md
Name: hd44780_framebuf

Overview:
Writable, parametrised HD44780 display shadow buffer. It replaces the fixed text ROM with a ROWS x COLS character RAM. The host writes it through a cursor-based stream port with auto-increment and wrap. The LCD driver reads it by 7-bit DDRAM address with 1-cycle latency. Per-row dirty flags tell the driver which lines need refreshing.

Parameters:
ROWS, 2, display lines. Legal values: 1, 2 or 4.
COLS, 16, characters per line. Legal range: 1..40 when ROWS<=2; 1..20 when ROWS=4.
FILL, 8'h20, blank character used by clear and returned for unmapped addresses.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
wr_valid  input  1  host character write request
wr_ready  output  1  buffer can accept a write; equals !busy
wr_data  input  8  character code to write at the cursor
pos_valid  input  1  load cursor from pos_row/pos_col
pos_row  input  2  target row
pos_col  input  6  target column
clr_start  input  1  start a clear sweep
busy  output  1  clear sweep in progress
cur_row  output  2  current cursor row
cur_col  output  6  current cursor column
rd_addr  input  7  DDRAM address from the LCD driver
rd_data  output  8  character at rd_addr, registered
dirty  output  ROWS  per-row "changed since last ack" flags
dirty_clr  input  ROWS  per-row acknowledge from the driver

Behaviour:
- Clock and reset: single clock domain. clk is the only clock; rst_n is synchronous, active-low, sampled on the rising edge of clk.
- Reset values: cur_row=0, cur_col=0, rd_data=FILL, dirty=all ones, busy=1, wr_ready=0.
- Reset start-up: on the first cycle after rst_n deasserts, the block runs a clear sweep. The RAM array itself is not reset.
- States:
  - CLEAR: writes FILL into one cell per cycle, linear index 0..ROWS*COLS-1, so the sweep takes exactly ROWS*COLS cycles. After the last cell it moves to IDLE, drops busy and puts the cursor at 0,0.
  - IDLE: accepts commands.
- Command priority in IDLE, highest first, evaluated per cycle:
  1. clr_start: enter CLEAR; set dirty to all ones; busy=1 from the next cycle.
  2. pos_valid: if pos_row<ROWS and pos_col<COLS, load the cursor; otherwise ignore the request and leave the cursor unchanged. Any wr_valid in the same cycle is dropped.
  3. wr_valid: write wr_data to RAM[cur_row][cur_col]; set dirty[cur_row]; advance the cursor.
- clr_start while in CLEAR: restart the sweep from index 0. pos_valid and wr_valid are ignored while busy.
- Cursor advance:
  - cur_col+1 if cur_col<COLS-1.
  - Otherwise cur_col=0 and cur_row+1.
  - From row ROWS-1, col COLS-1, wrap to 0,0.
- Read address map (HD44780 convention):
  - row0 base 0x00; row1 base 0x40; row2 base COLS; row3 base 0x40+COLS.
  - Valid only for rows that exist (row<ROWS) and column offsets 0..COLS-1.
  - rd_data is registered on the next clk edge. Unmapped address gives FILL.
- Read/write collisions: reading a cell in the same cycle as a write to it returns the old value; the new value is visible one cycle later.
- During CLEAR, reads return the current RAM contents, which may be partially cleared.
- Dirty flags:
  - dirty[r] is cleared by dirty_clr[r].
  - A set from a write or from clr_start wins over a simultaneous clear for the same row.
  - dirty_clr bits for absent rows are ignored.
- Reset asserted mid-sweep or mid-write: the reset values above apply on the next edge, then a fresh sweep runs after release.

Test Plan:
1. ROWS=2, COLS=16: release reset -> busy high exactly 32 cycles, then cursor 0,0; any rd_addr in 0x00..0x0F and 0x40..0x4F returns 8'h20; dirty=2'b11.
2. Write "Hello" from 0,0 -> cursor 0,5; rd_addr 0x00..0x04 returns 'H','e','l','l','o' one cycle after each address; dirty[0]=1; pulse dirty_clr=2'b01 -> dirty=2'b10.
3. pos 0,15, then write 'A','B' -> 'A' at 0x0F, 'B' at 0x40, cursor 1,1. Then pos 1,15 and write 'Z' -> cursor wraps to 0,0.
4. pos_valid with row=2 (ROWS=2) or col=16 -> cursor unchanged. pos_valid and wr_valid in the same cycle -> cursor loads, no RAM write. rd_addr 0x10 and 0x50 -> 8'h20.
5. ROWS=4, COLS=20: write 'X' at 2,0 and 'Y' at 3,19 -> rd_addr 0x14 returns 'X', 0x67 returns 'Y'. clr_start in the same cycle as dirty_clr=4'hF -> dirty=4'hF, busy for 80 cycles.
6. Assert rst_n=0 mid-sweep at cycle 10, release -> new 32-cycle sweep. Issue clr_start during that sweep -> sweep restarts from index 0, total busy = restart offset + 32. wr_valid while busy -> no write, cursor stays 0,0.
